// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves branch conditions in the EX stage. The unit has three states:
//   IDLE  - accepts a new branch, resolving it at once if operands are ready
//   WAIT  - holds the issuing stage until the forwarded operands are valid
//   FLUSH - keeps the front-end flush high for FLUSH_CYCLES cycles
//
// Branch types (Br_type):
//   000 none, 001 BEZ, 010 BNE, 011 JMP, 100 BEQ, 101 BLTZ, 110 BGEZ, 111 BGTZ
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst            asynchronous active-low reset
//   in_valid       branch-class instruction presented this cycle
//   in_ready       unit can accept (combinational, high only in IDLE)
//   Br_type        branch type, encoded as above
//   Val1           first operand (forwarded)
//   Src2_Val       second operand (forwarded)
//   operands_ready forwarding unit reports Val1/Src2_Val valid this cycle
//   PC_in          PC+4 of the branch
//   Offset         sign-extended word offset
//   stall          hold upstream stages (combinational)
//   Branch_Taken   registered one-cycle pulse on a taken decision
//   Branch_Addr    registered target PC_in + (Offset << 2), held until next accept
//   flush          registered; kill IF/ID contents
//
// Optional feature, enabled by defining BRANCH_RESOLVE_STATS_EN:
//   stat_clear        synchronous clear of the statistics counters
//   stat_resolved     saturating count of non-000 evaluations
//   stat_taken        saturating count of taken evaluations
//   stat_stall_cycles saturating count of cycles with stall high
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            Br_type,
  input  logic [DATA_WIDTH-1:0] Val1,
  input  logic [DATA_WIDTH-1:0] Src2_Val,
  input  logic                  operands_ready,
  input  logic [ADDR_WIDTH-1:0] PC_in,
  input  logic [ADDR_WIDTH-1:0] Offset,
  output logic                  stall,
  output logic                  Branch_Taken,
  output logic [ADDR_WIDTH-1:0] Branch_Addr,
  output logic                  flush
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [31:0]           stat_resolved,
  output logic [31:0]           stat_taken,
  output logic [31:0]           stat_stall_cycles
`endif
);

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEZ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_JMP  = 3'b011;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b101;
  localparam logic [2:0] BR_BGEZ = 3'b110;
  localparam logic [2:0] BR_BGTZ = 3'b111;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_reg;
  logic [2:0]      type_reg;
  logic [3:0]      cnt_reg;

  logic            accept;
  logic            br_active;
  logic            resolve_now;
  logic            taken_now;
  logic [2:0]      eval_type;
  logic [ADDR_WIDTH-1:0] target_next;

  // Condition check; the signed compares look only at the sign bit and
  // zero-ness of Val1, so no signed arithmetic is needed.
  function automatic logic branch_cond(input logic [2:0] t,
                                       input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
    logic r;
    r = 1'b0;
    case (t)
      BR_BEZ:  r = (a == '0);
      BR_BNE:  r = (a != b);
      BR_JMP:  r = 1'b1;
      BR_BEQ:  r = (a == b);
      BR_BLTZ: r = a[DATA_WIDTH-1];
      BR_BGEZ: r = ~a[DATA_WIDTH-1];
      BR_BGTZ: r = ~a[DATA_WIDTH-1] && (a != '0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign accept      = (state_reg == IDLE) && in_valid;
  assign br_active   = (Br_type != BR_NONE);
  assign in_ready    = (state_reg == IDLE);
  assign target_next = PC_in + (Offset << 2);

  // In WAIT the latched type is used; live operands are sampled every cycle.
  assign eval_type   = (state_reg == WAIT) ? type_reg : Br_type;

  // JMP never waits for operands: it resolves on the accept edge.
  assign resolve_now = (accept && br_active && (operands_ready || Br_type == BR_JMP)) ||
                       ((state_reg == WAIT) && operands_ready);
  assign taken_now   = resolve_now && branch_cond(eval_type, Val1, Src2_Val);

  assign stall = (state_reg == WAIT) ||
                 ((state_reg == IDLE) && in_valid && br_active &&
                  (Br_type != BR_JMP) && !operands_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      type_reg     <= '0;
      cnt_reg      <= '0;
      Branch_Taken <= 1'b0;
      Branch_Addr  <= '0;
      flush        <= 1'b0;
    end else begin
      Branch_Taken <= 1'b0;
      if (accept) begin
        type_reg    <= Br_type;
        Branch_Addr <= target_next;
      end
      if (state_reg == FLUSH) begin
        cnt_reg <= cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_reg <= IDLE;
          flush     <= 1'b0;
        end
      end else if (taken_now) begin
        state_reg    <= FLUSH;
        Branch_Taken <= 1'b1;
        flush        <= 1'b1;
        cnt_reg      <= FLUSH_LOAD;
      end else if (resolve_now) begin
        state_reg <= IDLE;
      end else if (accept && br_active) begin
        state_reg <= WAIT;
      end
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  // Index 0: resolved, 1: taken, 2: stall cycles.
  logic [2:0]  stat_inc;
  logic [31:0] stat_vec [3];

  assign stat_inc = {stall, taken_now, resolve_now};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [31:0] cnt_stat_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_stat_reg <= '0;
        end else if (stat_clear) begin
          cnt_stat_reg <= '0;
        end else if (stat_inc[gi] && (cnt_stat_reg != '1)) begin
          cnt_stat_reg <= cnt_stat_reg + 32'd1;
        end
      end
      assign stat_vec[gi] = cnt_stat_reg;
    end
  endgenerate

  assign stat_resolved     = stat_vec[0];
  assign stat_taken        = stat_vec[1];
  assign stat_stall_cycles = stat_vec[2];
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit (FLUSH_CYCLES = 3).
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  Br_type;
  logic [31:0] Val1;
  logic [31:0] Src2_Val;
  logic        operands_ready;
  logic [31:0] PC_in;
  logic [31:0] Offset;
  logic        stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Addr;
  logic        flush;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_resolved;
  logic [31:0] stat_taken;
  logic [31:0] stat_stall_cycles;
`endif

  int checks;
  int errors;

  branch_resolve_unit #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .FLUSH_CYCLES(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .Br_type       (Br_type),
    .Val1          (Val1),
    .Src2_Val      (Src2_Val),
    .operands_ready(operands_ready),
    .PC_in         (PC_in),
    .Offset        (Offset),
    .stall         (stall),
    .Branch_Taken  (Branch_Taken),
    .Branch_Addr   (Branch_Addr),
    .flush         (flush)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_clear       (stat_clear),
    .stat_resolved    (stat_resolved),
    .stat_taken       (stat_taken),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] v1, input logic [31:0] v2,
                       input logic rdy, input logic [31:0] pc, input logic [31:0] off);
    in_valid       = 1'b1;
    Br_type        = t;
    Val1           = v1;
    Src2_Val       = v2;
    operands_ready = rdy;
    PC_in          = pc;
    Offset         = off;
  endtask

  // Branch with operands ready at accept; checks decision and full flush window.
  task automatic run_branch(input string tag, input logic [2:0] t, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] pc,
                            input logic [31:0] off, input logic [31:0] exp_addr,
                            input logic exp_taken);
    drive(t, v1, v2, 1'b1, pc, off);
    #1;
    check({tag, "_stall"}, 64'(stall), 64'd0);
    step();
    in_valid = 1'b0;
    check({tag, "_taken"}, 64'(Branch_Taken), 64'(exp_taken));
    check({tag, "_flush"}, 64'(flush), 64'(exp_taken));
    check({tag, "_addr"}, 64'(Branch_Addr), 64'(exp_addr));
    if (exp_taken) begin
      step();
      check({tag, "_taken2"}, 64'(Branch_Taken), 64'd0);
      check({tag, "_flush2"}, 64'(flush), 64'd1);
      step();
      check({tag, "_flush3"}, 64'(flush), 64'd1);
      step();
      check({tag, "_flush_end"}, 64'(flush), 64'd0);
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    Br_type = 3'b000;
    Val1 = '0;
    Src2_Val = '0;
    operands_ready = 1'b0;
    PC_in = '0;
    Offset = '0;
`ifdef BRANCH_RESOLVE_STATS_EN
    stat_clear = 1'b0;
`endif
    step();
    step();
    check("rst_taken", 64'(Branch_Taken), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_addr", 64'(Branch_Addr), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    step();

    // BNE equal / unequal
    run_branch("bne_eq", 3'b010, 32'd5, 32'd5, 32'h1000, 32'd4, 32'h1010, 1'b0);
    run_branch("bne_ne", 3'b010, 32'd5, 32'd6, 32'h2000, 32'd1, 32'h2004, 1'b1);

    // Signed compares and BEZ/BEQ
    run_branch("bltz_m1", 3'b101, 32'hFFFF_FFFF, 32'd0, 32'h400, 32'd2, 32'h408, 1'b1);
    run_branch("bgtz_0", 3'b111, 32'd0, 32'd9, 32'h500, 32'd0, 32'h500, 1'b0);
    run_branch("bgez_0", 3'b110, 32'd0, 32'd9, 32'h600, 32'd3, 32'h60C, 1'b1);
    run_branch("bgtz_min", 3'b111, 32'h8000_0000, 32'd1, 32'h700, 32'hFFFF_FFFE, 32'h6F8, 1'b0);
    run_branch("bez_0", 3'b001, 32'd0, 32'd7, 32'h800, 32'd1, 32'h804, 1'b1);
    run_branch("beq_ne", 3'b100, 32'd3, 32'd4, 32'h900, 32'd1, 32'h904, 1'b0);

    // BEQ waiting on operands: stall for 4 cycles, target from accept-time PC
    drive(3'b100, 32'h10, 32'h10, 1'b0, 32'h3000, 32'h10);
    #1;
    check("wait_stall1", 64'(stall), 64'd1);
    step();
    in_valid = 1'b0;
    PC_in = 32'hDEAD_0000;
    Offset = 32'h55;
    #1;
    check("wait_stall2", 64'(stall), 64'd1);
    check("wait_ready", 64'(in_ready), 64'd0);
    step();
    check("wait_stall3", 64'(stall), 64'd1);
    check("wait_taken0", 64'(Branch_Taken), 64'd0);
    step();
    operands_ready = 1'b1;
    #1;
    check("wait_stall4", 64'(stall), 64'd1);
    step();
    check("wait_taken", 64'(Branch_Taken), 64'd1);
    check("wait_addr", 64'(Branch_Addr), 64'h3040);
    check("wait_stall_off", 64'(stall), 64'd0);
    step();
    step();
    step();
    check("wait_done", 64'(in_ready), 64'd1);

    // JMP with operands not ready; in_valid during FLUSH is ignored
    drive(3'b011, 32'd0, 32'd0, 1'b0, 32'h100, 32'hFFFF_FFFF);
    #1;
    check("jmp_stall", 64'(stall), 64'd0);
    step();
    check("jmp_taken", 64'(Branch_Taken), 64'd1);
    check("jmp_addr", 64'(Branch_Addr), 64'hFC);
    drive(3'b100, 32'd1, 32'd2, 1'b0, 32'h5000, 32'd1);
    #1;
    check("jmp_fl_stall", 64'(stall), 64'd0);
    check("jmp_fl_ready", 64'(in_ready), 64'd0);
    step();
    step();
    step();
    in_valid = 1'b0;
    #1;
    check("jmp_end_ready", 64'(in_ready), 64'd1);
    check("jmp_end_taken", 64'(Branch_Taken), 64'd0);
    check("jmp_end_addr", 64'(Branch_Addr), 64'hFC);
    check("jmp_end_stall", 64'(stall), 64'd0);

    // Reset during the second FLUSH cycle
    drive(3'b010, 32'd1, 32'd2, 1'b1, 32'h40, 32'd0);
    step();
    in_valid = 1'b0;
    check("mid_taken", 64'(Branch_Taken), 64'd1);
    step();
    check("mid_flush", 64'(flush), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_flush", 64'(flush), 64'd0);
    check("mid_rst_taken", 64'(Branch_Taken), 64'd0);
    check("mid_rst_addr", 64'(Branch_Addr), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b1;
    run_branch("post_rst", 3'b100, 32'd7, 32'd7, 32'h20, 32'd2, 32'h28, 1'b1);

`ifdef BRANCH_RESOLVE_STATS_EN
    // Fresh counters after reset, then 4 branches (2 taken) and 3 stall cycles
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("st_rst_res", 64'(stat_resolved), 64'd0);
    drive(3'b100, 32'd9, 32'd9, 1'b0, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    operands_ready = 1'b1;
    step();
    step();
    step();
    step();
    run_branch("st_bne", 3'b010, 32'd1, 32'd1, 32'h0, 32'h1, 32'h4, 1'b0);
    run_branch("st_jmp", 3'b011, 32'd0, 32'd0, 32'h0, 32'h2, 32'h8, 1'b1);
    run_branch("st_bez", 3'b001, 32'd5, 32'd0, 32'h0, 32'h3, 32'hC, 1'b0);
    check("st_resolved", 64'(stat_resolved), 64'd4);
    check("st_taken", 64'(stat_taken), 64'd2);
    check("st_stall", 64'(stat_stall_cycles), 64'd3);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    check("st_clr_res", 64'(stat_resolved), 64'd0);
    check("st_clr_taken", 64'(stat_taken), 64'd0);
    check("st_clr_stall", 64'(stat_stall_cycles), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
